// File: rtl/param_mimo_fifo.sv
// param_mimo_fifo: circular-buffer instruction FIFO with WRITE_PORT write lanes and READ_PORT read lanes.
// Define MIMO_FIFO_POP_BEFORE_PUSH_EN to let this cycle's pops free slots for this cycle's writes.
module param_mimo_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int WRITE_PORT = 2,
   parameter int READ_PORT  = 2,
   parameter int CW         = $clog2(DEPTH+1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush_i,
   input  logic [WRITE_PORT-1:0]                write_valid_i,
   input  logic [WRITE_PORT-1:0][DATA_WIDTH-1:0] write_data_i,
   output logic [$clog2(WRITE_PORT+1)-1:0]      write_num_o,
   output logic [READ_PORT-1:0]                 read_valid_o,
   output logic [READ_PORT-1:0][DATA_WIDTH-1:0] read_data_o,
   input  logic [READ_PORT-1:0]                 issue_i,
   output logic [CW-1:0]                        count_o
);
   localparam int AW  = $clog2(DEPTH);
   localparam int WNW = $clog2(WRITE_PORT+1);

   // Handshake: write lanes 0..write_num_o-1 are taken at the edge, the rest must be re-presented;
   // read lane i pops at the edge only when issue_i[i] and read_valid_o[i] are both set.
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         head, tail;
   logic [CW-1:0]         count;
   logic [CW-1:0]         pop_n, req_n, free;

   always_comb begin
      read_valid_o = '0;
      read_data_o  = '0;
      for (int i = 0; i < READ_PORT; i++) begin
         read_valid_o[i] = (count > CW'(i));
         read_data_o[i]  = mem[head + AW'(i)];
      end
   end

   always_comb begin
      pop_n = '0;
      req_n = '0;
      for (int i = 0; i < READ_PORT; i++)
         pop_n = pop_n + CW'(issue_i[i] & read_valid_o[i]);
      for (int k = 0; k < WRITE_PORT; k++)
         req_n = req_n + CW'(write_valid_i[k]);
`ifdef MIMO_FIFO_POP_BEFORE_PUSH_EN
      free = CW'(DEPTH) - count + pop_n;
`else
      free = CW'(DEPTH) - count;
`endif
   end

   // Reset and flush both force zero acceptance regardless of free space.
   always_comb begin
      write_num_o = '0;
      if (rst_n && !flush_i)
         write_num_o = (req_n <= free) ? WNW'(req_n) : WNW'(free);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop_n);
         tail  <= tail + AW'(write_num_o);
         count <= count + CW'(write_num_o) - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush_i) begin
         for (int k = 0; k < WRITE_PORT; k++)
            if (k < int'(write_num_o))
               mem[tail + AW'(k)] <= write_data_i[k];
      end
   end

   assign count_o = count;

   // Illegal-stimulus checks; the datapath itself only ever uses the masked pop count.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert ((write_valid_i & (write_valid_i + WRITE_PORT'(1))) == '0);
         assert ((issue_i & (issue_i + READ_PORT'(1))) == '0);
         assert ((issue_i & ~read_valid_o) == '0);
      end
   end
endmodule
